// File: rtl/sram_arbiter_if.sv
// -----------------------------------------------------------------------------
// sram_arbiter_if
// Bundles the two requester ports (A and B) and the single sram_core port that
// the arbiter shares between them.
//   slave  : arbiter side  - takes requests, returns grants/read data,
//                            drives the SRAM port, reports init_done
//   master : environment side - drives requests and mem_rdata
// Signals per requester x in {a, b}:
//   x_req, x_we, x_addr, x_wdata : request (held stable until x_gnt)
//   x_gnt                        : request accepted this cycle
//   x_rvalid, x_rdata            : read result, one cycle after a read grant
// SRAM port: mem_we, mem_addr, mem_wdata (to core), mem_rdata (from core)
// -----------------------------------------------------------------------------
interface sram_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_gnt;
    logic              a_rvalid;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_gnt;
    logic              b_rvalid;
    logic [DATA_W-1:0] b_rdata;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              init_done;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_rvalid, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_gnt, b_rvalid, b_rdata,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output init_done
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_rvalid, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  init_done
    );
endinterface

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
// Front end for a single-port sram_core (write enable, registered read,
// 1-cycle read latency). After reset it sweeps every address writing INIT_VAL,
// then shares the port between requesters A and B with round-robin priority
// and steers each read result back to whoever issued the read.
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : synchronous reset, active high
//   bus  : sram_arbiter_if.slave (requester A/B handshakes, SRAM port,
//          init_done)
// -----------------------------------------------------------------------------
module sram_arbiter #(
    parameter int                 ADDR_W   = 4,
    parameter int                 DATA_W   = 8,
    parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
    input  logic           clk,
    input  logic           rst,
    sram_arbiter_if.slave  bus
);
    typedef enum logic {INIT, RUN} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] init_cnt, init_cnt_nxt;
    logic              rr_b, rr_b_nxt;      // 1: B wins the next contention
    logic              a_gnt, b_gnt;
    logic              a_rvalid_q, b_rvalid_q;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= INIT;
            init_cnt   <= '0;
            rr_b       <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            init_cnt   <= init_cnt_nxt;
            rr_b       <= rr_b_nxt;
            // Read data appears on mem_rdata one cycle after the grant, so the
            // valid flag is the grant delayed by one register.
            a_rvalid_q <= a_gnt & ~bus.a_we;
            b_rvalid_q <= b_gnt & ~bus.b_we;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        rr_b_nxt     = rr_b;
        a_gnt        = 1'b0;
        b_gnt        = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;

        unique case (state)
            INIT: begin
                // Requests are simply not granted here; requesters keep
                // holding them until the sweep finishes.
                mem_we       = ~rst;
                mem_addr     = init_cnt;
                mem_wdata    = INIT_VAL;
                init_cnt_nxt = init_cnt + ADDR_W'(1);
                if (init_cnt == LAST_ADDR) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!rst) begin
                    // A lone requester always wins; on contention the pointer
                    // decides.
                    a_gnt = bus.a_req & (~bus.b_req | ~rr_b);
                    b_gnt = bus.b_req & (~bus.a_req |  rr_b);
                    if (a_gnt) begin
                        mem_we    = bus.a_we;
                        mem_addr  = bus.a_addr;
                        mem_wdata = bus.a_wdata;
                        rr_b_nxt  = 1'b1;
                    end else if (b_gnt) begin
                        mem_we    = bus.b_we;
                        mem_addr  = bus.b_addr;
                        mem_wdata = bus.b_wdata;
                        rr_b_nxt  = 1'b0;
                    end
                end
            end
            default: state_nxt = INIT;
        endcase
    end

    assign bus.a_gnt     = a_gnt;
    assign bus.b_gnt     = b_gnt;
    assign bus.a_rvalid  = a_rvalid_q;
    assign bus.b_rvalid  = b_rvalid_q;
    // Only one read can be in flight per cycle, so both requesters can see the
    // raw SRAM output; rvalid tells each whether it is theirs.
    assign bus.a_rdata   = bus.mem_rdata;
    assign bus.b_rdata   = bus.mem_rdata;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.init_done = (state == RUN);
endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
// Drives sram_arbiter through its interface, models the attached sram_core,
// and checks grants, SRAM port activity and read returns against a
// transaction-level reference model (memory array + whose-turn flag).
// -----------------------------------------------------------------------------
module tb_sram_arbiter;
    localparam int                ADDR_W   = 4;
    localparam int                DATA_W   = 8;
    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [DATA_W-1:0] INIT_VAL = 8'h00;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INIT_VAL(INIT_VAL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // sram_core model: write enable, registered read (old data on same-cycle write)
    logic [DATA_W-1:0] core [DEPTH];
    always @(posedge clk) begin
        if (bus.mem_we) core[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= core[bus.mem_addr];
    end

    int errors = 0;
    int checks = 0;

    // Reference model: memory contents, who is served on contention, init
    // countdown, and the read result owed in the coming cycle.
    logic [DATA_W-1:0] ref_mem [DEPTH];
    bit                turn_b;
    bit                running;
    int                init_left;
    bit                m_rva, m_rvb;
    logic [DATA_W-1:0] m_rd;

    function automatic void exp_grants(output bit ga, output bit gb);
        ga = 1'b0;
        gb = 1'b0;
        if (running && !rst) begin
            if (bus.a_req && bus.b_req) begin
                ga = !turn_b;
                gb = turn_b;
            end else begin
                ga = bus.a_req;
                gb = bus.b_req;
            end
        end
    endfunction

    // Advance the model across the coming clock edge using this cycle's inputs.
    task automatic model_clock();
        bit ga, gb;
        exp_grants(ga, gb);
        m_rva = 1'b0;
        m_rvb = 1'b0;
        if (rst) begin
            running   = 1'b0;
            init_left = DEPTH;
            turn_b    = 1'b0;
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = INIT_VAL;
        end else if (!running) begin
            init_left--;
            if (init_left == 0) running = 1'b1;
        end else begin
            if (ga) begin
                if (bus.a_we) ref_mem[bus.a_addr] = bus.a_wdata;
                else begin m_rva = 1'b1; m_rd = ref_mem[bus.a_addr]; end
                turn_b = 1'b1;
            end else if (gb) begin
                if (bus.b_we) ref_mem[bus.b_addr] = bus.b_wdata;
                else begin m_rvb = 1'b1; m_rd = ref_mem[bus.b_addr]; end
                turn_b = 1'b0;
            end
        end
    endtask

    // One clock: update the model, then land just after the rising edge.
    task automatic cyc();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(bit req, bit we, logic [ADDR_W-1:0] addr, logic [DATA_W-1:0] wdata);
        bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata;
    endtask

    task automatic set_b(bit req, bit we, logic [ADDR_W-1:0] addr, logic [DATA_W-1:0] wdata);
        bus.b_req = req; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata;
    endtask

    // Reset, init sweep, and a read held through INIT.
    task automatic test_reset();
        rst = 1'b1;
        set_a(1'b1, 1'b0, 4'd5, 8'h00);
        set_b(1'b0, 1'b0, 4'd0, 8'h00);
        cyc(); cyc(); #1;
        checks++; if (bus.a_gnt !== 1'b0) begin errors++; $display("FAIL rst_a_gnt: got %b want 0", bus.a_gnt); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b want 0", bus.mem_we); end
        checks++; if (bus.a_rvalid !== 1'b0 || bus.b_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b%b want 00", bus.a_rvalid, bus.b_rvalid); end
        checks++; if (bus.init_done !== 1'b0) begin errors++; $display("FAIL rst_init_done: got %b want 0", bus.init_done); end
        cyc(); rst = 1'b0; #1;
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== ADDR_W'(i) || bus.mem_wdata !== INIT_VAL) begin
                errors++; $display("FAIL init_sweep[%0d]: got we=%b addr=%0d data=%0h want we=1 addr=%0d data=%0h", i, bus.mem_we, bus.mem_addr, bus.mem_wdata, i, INIT_VAL);
            end
            checks++; if (bus.a_gnt !== 1'b0 || bus.init_done !== 1'b0) begin
                errors++; $display("FAIL init_holdoff[%0d]: got gnt=%b done=%b want 0 0", i, bus.a_gnt, bus.init_done);
            end
            cyc(); #1;
        end
        checks++; if (bus.init_done !== 1'b1) begin errors++; $display("FAIL init_done_rise: got %b want 1", bus.init_done); end
        checks++; if (bus.a_gnt !== 1'b1 || bus.mem_addr !== 4'd5 || bus.mem_we !== 1'b0) begin
            errors++; $display("FAIL first_run_gnt: got gnt=%b addr=%0d we=%b want 1 5 0", bus.a_gnt, bus.mem_addr, bus.mem_we);
        end
        cyc(); set_a(1'b0, 1'b0, 4'd0, 8'h00); #1;
        checks++; if (bus.a_rvalid !== 1'b1 || bus.a_rdata !== INIT_VAL) begin
            errors++; $display("FAIL init_readback: got rvalid=%b data=%0h want 1 %0h", bus.a_rvalid, bus.a_rdata, INIT_VAL);
        end
    endtask

    // A alone: write 42 to addr 2, read it back.
    task automatic test_single();
        cyc(); set_a(1'b1, 1'b1, 4'd2, 8'd42); #1;
        checks++; if (bus.a_gnt !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 4'd2 || bus.mem_wdata !== 8'd42) begin
            errors++; $display("FAIL single_write: got gnt=%b we=%b addr=%0d data=%0d want 1 1 2 42", bus.a_gnt, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        cyc(); bus.a_we = 1'b0; #1;
        checks++; if (bus.a_gnt !== 1'b1 || bus.mem_we !== 1'b0 || bus.a_rvalid !== 1'b0) begin
            errors++; $display("FAIL single_read_gnt: got gnt=%b we=%b rvalid=%b want 1 0 0", bus.a_gnt, bus.mem_we, bus.a_rvalid);
        end
        cyc(); set_a(1'b0, 1'b0, 4'd0, 8'h00); #1;
        checks++; if (bus.a_rvalid !== 1'b1 || bus.a_rdata !== 8'd42 || bus.b_rvalid !== 1'b0) begin
            errors++; $display("FAIL single_read_data: got a_rvalid=%b data=%0d b_rvalid=%b want 1 42 0", bus.a_rvalid, bus.a_rdata, bus.b_rvalid);
        end
    endtask

    // Both hold reads: grants alternate starting with A, rvalid follows by one.
    task automatic test_contention();
        cyc(); set_a(1'b1, 1'b1, 4'd7, 8'd99); #1;
        checks++; if (bus.a_gnt !== 1'b1) begin errors++; $display("FAIL preload_a: got %b want 1", bus.a_gnt); end
        cyc(); set_a(1'b0, 1'b0, 4'd0, 8'h00); set_b(1'b1, 1'b1, 4'd0, 8'd13); #1;
        checks++; if (bus.b_gnt !== 1'b1) begin errors++; $display("FAIL preload_b: got %b want 1", bus.b_gnt); end
        cyc(); set_a(1'b1, 1'b0, 4'd7, 8'h00); set_b(1'b1, 1'b0, 4'd0, 8'h00);
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++; if (bus.a_gnt !== (k % 2 == 0) || bus.b_gnt !== (k % 2 == 1)) begin
                errors++; $display("FAIL contention_gnt[%0d]: got a=%b b=%b want a=%0d b=%0d", k, bus.a_gnt, bus.b_gnt, k % 2 == 0, k % 2 == 1);
            end
            if (k > 0) begin
                checks++; if (bus.a_rvalid !== (k % 2 == 1) || bus.b_rvalid !== (k % 2 == 0)
                              || bus.a_rdata !== ((k % 2 == 1) ? 8'd99 : 8'd13)) begin
                    errors++; $display("FAIL contention_rv[%0d]: got a=%b b=%b data=%0d", k, bus.a_rvalid, bus.b_rvalid, bus.a_rdata);
                end
            end
            cyc();
        end
        set_a(1'b0, 1'b0, 4'd0, 8'h00); set_b(1'b0, 1'b0, 4'd0, 8'h00); #1;
        checks++; if (bus.b_rvalid !== 1'b1 || bus.a_rvalid !== 1'b0 || bus.b_rdata !== 8'd13) begin
            errors++; $display("FAIL contention_last: got a=%b b=%b data=%0d want 0 1 13", bus.a_rvalid, bus.b_rvalid, bus.b_rdata);
        end
    endtask

    // A writes 0x5A to addr 3, B reads addr 3 in the very next cycle.
    task automatic test_hazard();
        cyc(); set_a(1'b1, 1'b1, 4'd3, 8'h5A); #1;
        checks++; if (bus.a_gnt !== 1'b1) begin errors++; $display("FAIL hazard_wr_gnt: got %b want 1", bus.a_gnt); end
        cyc(); set_a(1'b0, 1'b0, 4'd0, 8'h00); set_b(1'b1, 1'b0, 4'd3, 8'h00); #1;
        checks++; if (bus.b_gnt !== 1'b1 || bus.mem_addr !== 4'd3) begin
            errors++; $display("FAIL hazard_rd_gnt: got gnt=%b addr=%0d want 1 3", bus.b_gnt, bus.mem_addr);
        end
        cyc(); set_b(1'b0, 1'b0, 4'd0, 8'h00); #1;
        checks++; if (bus.b_rvalid !== 1'b1 || bus.b_rdata !== 8'h5A || bus.a_rvalid !== 1'b0) begin
            errors++; $display("FAIL hazard_data: got b_rvalid=%b data=%0h a_rvalid=%b want 1 5a 0", bus.b_rvalid, bus.b_rdata, bus.a_rvalid);
        end
    endtask

    // Random traffic with held-until-granted requests, checked against the model.
    task automatic test_random();
        bit a_pend = 1'b0, b_pend = 1'b0;
        bit ga, gb;
        logic              exp_we;
        logic [ADDR_W-1:0] exp_addr;
        logic [DATA_W-1:0] exp_wdata;
        for (int i = 0; i < 300; i++) begin
            cyc();
            if (!a_pend && $urandom_range(0, 99) < 60) begin
                a_pend = 1'b1;
                set_a(1'b1, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, DEPTH - 1)), DATA_W'($urandom));
            end
            if (!b_pend && $urandom_range(0, 99) < 60) begin
                b_pend = 1'b1;
                set_b(1'b1, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, DEPTH - 1)), DATA_W'($urandom));
            end
            bus.a_req = a_pend;
            bus.b_req = b_pend;
            #1;
            exp_grants(ga, gb);
            exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
            if (ga) begin exp_we = bus.a_we; exp_addr = bus.a_addr; exp_wdata = bus.a_wdata; end
            else if (gb) begin exp_we = bus.b_we; exp_addr = bus.b_addr; exp_wdata = bus.b_wdata; end
            checks++; if (bus.a_gnt !== ga || bus.b_gnt !== gb) begin
                errors++; $display("FAIL rand_gnt[%0d]: got a=%b b=%b want a=%b b=%b", i, bus.a_gnt, bus.b_gnt, ga, gb);
            end
            checks++; if (bus.mem_we !== exp_we || bus.mem_addr !== exp_addr || bus.mem_wdata !== exp_wdata) begin
                errors++; $display("FAIL rand_mem[%0d]: got we=%b addr=%0d data=%0h want %b %0d %0h", i, bus.mem_we, bus.mem_addr, bus.mem_wdata, exp_we, exp_addr, exp_wdata);
            end
            checks++; if (bus.a_rvalid !== m_rva || bus.b_rvalid !== m_rvb) begin
                errors++; $display("FAIL rand_rvalid[%0d]: got a=%b b=%b want a=%b b=%b", i, bus.a_rvalid, bus.b_rvalid, m_rva, m_rvb);
            end
            if (m_rva || m_rvb) begin
                checks++; if ((m_rva ? bus.a_rdata : bus.b_rdata) !== m_rd) begin
                    errors++; $display("FAIL rand_rdata[%0d]: got %0h want %0h", i, m_rva ? bus.a_rdata : bus.b_rdata, m_rd);
                end
            end
            if (ga) a_pend = 1'b0;
            if (gb) b_pend = 1'b0;
        end
        cyc(); set_a(1'b0, 1'b0, 4'd0, 8'h00); set_b(1'b0, 1'b0, 4'd0, 8'h00);
    endtask

    // rst asserted together with an A read request: no grant, no rvalid,
    // the sweep restarts at 0 and memory comes back cleared.
    task automatic test_reset_mid_read();
        cyc(); set_a(1'b1, 1'b0, 4'd7, 8'h00); rst = 1'b1; #1;
        checks++; if (bus.a_gnt !== 1'b0 || bus.mem_we !== 1'b0) begin
            errors++; $display("FAIL midrst_gate: got gnt=%b we=%b want 0 0", bus.a_gnt, bus.mem_we);
        end
        cyc(); rst = 1'b0; #1;
        checks++; if (bus.a_rvalid !== 1'b0 || bus.init_done !== 1'b0) begin
            errors++; $display("FAIL midrst_after: got rvalid=%b done=%b want 0 0", bus.a_rvalid, bus.init_done);
        end
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== ADDR_W'(i) || bus.a_gnt !== 1'b0 || bus.init_done !== 1'b0) begin
                errors++; $display("FAIL midrst_sweep[%0d]: got we=%b addr=%0d gnt=%b done=%b", i, bus.mem_we, bus.mem_addr, bus.a_gnt, bus.init_done);
            end
            cyc(); #1;
        end
        checks++; if (bus.init_done !== 1'b1 || bus.a_gnt !== 1'b1) begin
            errors++; $display("FAIL midrst_resume: got done=%b gnt=%b want 1 1", bus.init_done, bus.a_gnt);
        end
        cyc(); set_a(1'b0, 1'b0, 4'd0, 8'h00); #1;
        checks++; if (bus.a_rvalid !== 1'b1 || bus.a_rdata !== INIT_VAL) begin
            errors++; $display("FAIL midrst_cleared: got rvalid=%b data=%0h want 1 %0h", bus.a_rvalid, bus.a_rdata, INIT_VAL);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) core[i] = DATA_W'(8'hC0 + i);
        test_reset();
        test_single();
        test_contention();
        test_hazard();
        test_random();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
Front-end controller for the 16x8 `sram_core` (write-enable, registered read, 1-cycle read latency). After reset it clears every location to a known value. It then shares the single SRAM port between two requesters, A and B, using round-robin arbitration. It routes each registered read result back to the requester that issued the read.

Parameters:
ADDR_W, 4, SRAM address width; depth = 2**ADDR_W
DATA_W, 8, SRAM data width
INIT_VAL, 0, value written to every location during the init sweep

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
a_req  in  1  requester A has a valid request
a_we  in  1  A: 1 = write, 0 = read
a_addr  in  ADDR_W  A address
a_wdata  in  DATA_W  A write data
a_gnt  out  1  A request accepted this cycle (combinational)
a_rvalid  out  1  A read data valid this cycle
a_rdata  out  DATA_W  A read data; meaningful only when a_rvalid
b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same as A, for requester B
mem_we  out  1  to sram_core we
mem_addr  out  ADDR_W  to sram_core addr
mem_wdata  out  DATA_W  to sram_core wdata
mem_rdata  in  DATA_W  from sram_core rdata; valid 1 cycle after addr
init_done  out  1  high once init sweep is complete

Behaviour:
- FSM states: INIT, RUN.
- rst high: state <= INIT, init counter <= 0, rr pointer <= A, rvalid flags <= 0. All grants and mem_we are 0 while rst is high.
- INIT:
  - mem_we=1, mem_addr=counter, mem_wdata=INIT_VAL; counter increments each cycle.
  - After the cycle that writes address 2**ADDR_W-1, state <= RUN.
  - Sweep takes exactly 2**ADDR_W cycles after rst deasserts.
  - a_gnt=b_gnt=0 throughout; requests are held off, not dropped.
- RUN:
  - init_done=1 (registered: equals state==RUN).
  - Grant is combinational in the same cycle as the request.
  - Only one requester active: grant it.
  - Both active: grant the requester named by the rr pointer.
  - On any grant, the pointer moves to the other requester. With no grant, the pointer holds.
  - Requester handshake: keep req, we, addr and wdata stable until gnt is seen high. The transfer completes in the gnt cycle; the requester may issue a new request the next cycle.
  - mem_we/mem_addr/mem_wdata come from the granted requester. mem_we = granted & we.
  - No grant: mem_we=0, mem_addr=0, mem_wdata=0.
- Read return:
  - x_rvalid is a registered flag: x_rvalid <= x_gnt & ~x_we.
  - So rvalid pulses exactly one cycle after a read grant. x_rdata = mem_rdata (pass-through).
  - Writes never raise rvalid.
  - Back-to-back reads from alternating requesters give one rvalid per cycle, never both in the same cycle.
- Throughput: one SRAM access per cycle, sustained.
- Write-then-read to the same address in consecutive grants returns the new data.
- Reset mid-operation:
  - A pending rvalid is suppressed; rvalid is 0 in the cycle after rst.
  - The FSM re-enters INIT and the memory is re-cleared.
  - init_done drops in the cycle after rst is sampled.

Test Plan:
- Init sweep: pulse rst; mem_we=1 with addr 0..15 on consecutive cycles; init_done rises 16 cycles after rst deasserts. A read of addr 5 then returns 0x00 with a_rvalid one cycle after a_gnt.
- Single requester: A writes 42 to addr 2, then reads addr 2. a_gnt is immediate; a_rvalid comes the next cycle with a_rdata=42; b_rvalid stays 0.
- Contention: A and B both hold read requests (A addr 7 = 99, B addr 0 = 13, preloaded). Grants alternate A,B,A,B starting with A. rvalid alternates one cycle later with 99/13.
- Write/read hazard: A writes 0x5A to addr 3; B reads addr 3 in the next granted cycle; b_rdata=0x5A.
- Requests during INIT: a_req held from rst deassert; a_gnt stays 0 for 16 cycles, then asserts in the first RUN cycle.
- Reset mid-read: assert rst in the cycle of an A read grant. a_rvalid is 0 the next cycle, the init sweep restarts at addr 0, and init_done is 0 until the sweep completes.
